// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq block: opcodes, FSM encoding and flag bit positions.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_ASR1 = 4'h9;
    localparam logic [3:0] OP_ROR1 = 4'hA;
    localparam logic [3:0] OP_EQ   = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_SLT  = 4'hD;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLG_CARRY = 0;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_NEG   = 2;
    localparam int FLG_OVF   = 3;
    localparam int FLG_W     = 4;

    typedef logic [FLG_W-1:0] flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod_nxt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] step_sum;

    // prod_nxt is the accumulator after the current step, so the final product is
    // available combinationally on the cycle done is high.
    always_comb begin
        step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod_nxt = step_sum;
        done     = busy_q && (cnt_q == LAST);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
        end else if (busy_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags and an iterative multiplier.
// Define ALU_SEQ_SAT_EN to make ADD/SUB saturate instead of wrapping.
//
//   state   | meaning
//   IDLE    | accepting operations; single-cycle results load on the accept edge
//   MUL     | multiplier stepping; in_ready held low until the product loads
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   out_hi_q, out_hi_d;
    flags_t             flags_q, flags_d;
    logic               out_valid_q, out_valid_d;

    logic               in_fire, mul_start, mul_busy, mul_done, mul_fin;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    flags_t             alu_flags;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .a        (x),
        .b        (y),
        .busy     (mul_busy),
        .done     (mul_done),
        .prod_nxt (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_fin)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        in_fire   = in_valid && in_ready;
        mul_start = in_fire && (ctrl == OP_MUL);
        mul_fin   = (state_q == ST_MUL) && mul_busy && mul_done;
    end

    // Single-cycle datapath; ovf always comes from the raw sum/difference.
    always_comb begin
        sum_w   = {1'b0, x} + {1'b0, y};
        diff_w  = {1'b0, x} - {1'b0, y};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ctrl)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (x[WIDTH-1] == y[WIDTH-1]) && (sum_w[WIDTH-1] != x[WIDTH-1]);
`ifdef ALU_SEQ_SAT_EN
                if (sum_w[WIDTH]) alu_res = '1;
`endif
            end
            OP_SUB: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = diff_w[WIDTH];
                alu_v   = (x[WIDTH-1] != y[WIDTH-1]) && (diff_w[WIDTH-1] != x[WIDTH-1]);
`ifdef ALU_SEQ_SAT_EN
                if (diff_w[WIDTH]) alu_res = '0;
`endif
            end
            OP_AND:  alu_res = x & y;
            OP_OR:   alu_res = x | y;
            OP_NOT:  alu_res = ~x;
            OP_XOR:  alu_res = x ^ y;
            OP_NOR:  alu_res = ~(x | y);
            OP_SHL:  alu_res = y << x[SHW-1:0];
            OP_SHR:  alu_res = y >> x[SHW-1:0];
            OP_ASR1: alu_res = {x[WIDTH-1], x[WIDTH-1:1]};
            OP_ROR1: alu_res = {x[0], x[WIDTH-1:1]};
            OP_EQ:   alu_res = WIDTH'(x == y);
            OP_SLT:  alu_res = WIDTH'($signed(x) < $signed(y));
            default: alu_res = '0;
        endcase
        alu_flags            = '0;
        alu_flags[FLG_CARRY] = alu_c;
        alu_flags[FLG_ZERO]  = (alu_res == '0);
        alu_flags[FLG_NEG]   = alu_res[WIDTH-1];
        alu_flags[FLG_OVF]   = alu_v;
    end

    always_comb begin
        out_d       = out_q;
        out_hi_d    = out_hi_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        if (in_fire && (ctrl != OP_MUL)) begin
            out_d       = alu_res;
            out_hi_d    = '0;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
        end else if (mul_fin) begin
            out_d              = mul_prod[WIDTH-1:0];
            out_hi_d           = mul_prod[2*WIDTH-1:WIDTH];
            flags_d            = '0;
            flags_d[FLG_ZERO]  = (mul_prod[WIDTH-1:0] == '0);
            flags_d[FLG_NEG]   = mul_prod[WIDTH-1];
            out_valid_d        = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_hi_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_hi_q    <= out_hi_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign carry     = flags_q[FLG_CARRY];
    assign zero      = flags_q[FLG_ZERO];
    assign neg       = flags_q[FLG_NEG];
    assign ovf       = flags_q[FLG_OVF];

endmodule
